round_robin_arbiter: RTL and testbench
======================================

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles before forced handoff (used only when RR_ARB_TIMEOUT_EN is defined); legal range 1..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_a, req_b, req_c, req_d  input  1 each  request lines; a high level requests the shared resource and holds an owned grant.
REQ-005 gnt_a, gnt_b, gnt_c, gnt_d  output  1 each  registered grants, at most one high at a time.
REQ-006 gnt_valid  output  1  high when any gnt_* is high.
REQ-007 gnt_id  output  2  index of the current owner (a=0, b=1, c=2, d=3); holds the last owner when gnt_valid is low.
REQ-008 timeout  output  1  one-cycle pulse on a forced handoff; tied 0 when RR_ARB_TIMEOUT_EN is undefined.

Function
REQ-009 The FSM SHALL have two states: IDLE (no grant) and OWN (exactly one grant high).
REQ-010 In IDLE with any req high, the next state SHALL be OWN, granting the first requester found in circular order starting at gnt_id+1.
REQ-011 In IDLE with no req high, all outputs SHALL hold, with gnt_* low.
REQ-012 Grant latency SHALL be exactly one cycle: a req sampled high at edge N SHALL produce its gnt_* high after edge N.
REQ-013 In OWN, while the owner's req stays high and no forced handoff applies, the grant SHALL be held unchanged.
REQ-014 In OWN, when the owner's req is sampled low and another req is high, the grant SHALL move directly, with no bubble cycle, to the next requester in circular order after the owner.
REQ-015 In OWN, when the owner's req is sampled low and no other req is high, the next state SHALL be IDLE, with all gnt_* low and gnt_id unchanged.
REQ-016 The owner SHALL be excluded from the circular search whenever its req is low, so a released requester cannot be re-granted in the same cycle.
REQ-017 Simultaneous requests SHALL be resolved only by the circular pointer, never by fixed priority, except immediately after reset.
REQ-018 gnt_* SHALL be one-hot or zero on every cycle, and gnt_valid SHALL equal the OR of gnt_*.
REQ-019 A req pulse shorter than one cycle that is not sampled high at an edge SHALL have no effect.

Reset
REQ-020 While rst is sampled high: state = IDLE, gnt_a..gnt_d = 0, gnt_valid = 0, gnt_id = 3, hold counter = 0, timeout = 0.
REQ-021 The reset value gnt_id = 3 SHALL give req_a highest priority on the first arbitration after reset.
REQ-022 A reset asserted during OWN SHALL drop the grant at the next edge, regardless of req levels.
REQ-023 Requests sampled in the same cycle as rst SHALL be ignored; arbitration resumes on the first edge with rst low.

Configuration
REQ-024 Macro RR_ARB_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on each new grant and increment each OWN cycle, saturating at MAX_HOLD.
REQ-025 With RR_ARB_TIMEOUT_EN defined: when the counter equals MAX_HOLD and any other req is high, the grant SHALL move to the next requester in circular order, and timeout SHALL pulse high for that cycle.
REQ-026 With RR_ARB_TIMEOUT_EN defined: when the counter equals MAX_HOLD and no other req is high, the owner SHALL keep the grant, with no timeout pulse.
REQ-027 With RR_ARB_TIMEOUT_EN undefined: no counter SHALL exist, grants SHALL be held while the owner's req stays high, and timeout SHALL be constant 0.

Verification
REQ-028 Reset, then all four req high from cycle 0 and each owner dropping its req one cycle after being granted -> grant order a, b, c, d, a; gnt_id 0, 1, 2, 3, 0.
REQ-029 Only req_c high for 20 cycles with the macro undefined -> gnt_c high for 19 cycles starting one cycle after req_c, timeout always 0.
REQ-030 Macro defined with MAX_HOLD=4, req_a and req_b held high -> gnt_a for 4 cycles, then gnt_b for 4 cycles, alternating, with a timeout pulse at each handoff.
REQ-031 gnt_b owned; req_b drops while req_a and req_d are high -> the next cycle grants d (circular after b), with no idle cycle.
REQ-032 rst pulsed for one cycle while gnt_c is high -> gnt_* all 0 and gnt_id = 3 after the edge; with req_c and req_a high afterwards -> a granted first.
REQ-033 Random req stimulus for 10,000 cycles -> never more than one gnt high, no grant to a requester whose req was low at the prior edge, and no requester starved longer than 3 grants (or 3*MAX_HOLD cycles with the macro defined).

Source files
------------

// File: rtl/round_robin_arbiter_if.sv
// round_robin_arbiter_if: request/grant bundle between four requesters and the arbiter.
// Latency: none (wires only); grant timing is set by the arbiter.
// Backpressure: a requester holds its grant by keeping its req high.
//
// Signals:
//   req_a..req_d  requester -> arbiter, level requests
//   gnt_a..gnt_d  arbiter -> requester, registered one-hot grants
//   gnt_valid     arbiter -> requester, OR of the grants
//   gnt_id        arbiter -> requester, index of current/last owner (a=0..d=3)
//   timeout       arbiter -> requester, one-cycle pulse on a forced handoff
// Modports: master = requester side, slave = arbiter side.
interface round_robin_arbiter_if;
    logic       req_a;
    logic       req_b;
    logic       req_c;
    logic       req_d;
    logic       gnt_a;
    logic       gnt_b;
    logic       gnt_c;
    logic       gnt_d;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;

    modport master (
        output req_a, req_b, req_c, req_d,
        input  gnt_a, gnt_b, gnt_c, gnt_d, gnt_valid, gnt_id, timeout
    );

    modport slave (
        input  req_a, req_b, req_c, req_d,
        output gnt_a, gnt_b, gnt_c, gnt_d, gnt_valid, gnt_id, timeout
    );
endinterface

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: 4-way round-robin arbiter for one shared resource.
// Latency: a req sampled high at edge N shows its registered grant right after edge N.
// Backpressure: the owner keeps the grant while its req stays high (optionally capped).
//
// Ports:
//   clk       single clock, all state updates on its rising edge
//   rst       synchronous active-high reset
//   bus       round_robin_arbiter_if.slave (req_a..d in; gnt_a..d, gnt_valid,
//             gnt_id, timeout out)
// Parameter MAX_HOLD (1..255): consecutive grant cycles before a forced handoff.
// Optional feature macro RR_ARB_TIMEOUT_EN: enables the hold counter, forced
// handoff and the timeout pulse. Undefined: owner holds indefinitely, timeout = 0.
module round_robin_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    round_robin_arbiter_if.slave bus
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("round_robin_arbiter: MAX_HOLD must be in 1..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] gnt_vec;     // registered one-hot grant, bit 0 = a
    logic [1:0] owner_id;    // current owner, or last owner while IDLE

    logic [3:0] req_vec;
    logic [3:0] cand_vec;    // requests eligible for the circular search
    logic       owner_req;
    logic       pick_vld;
    logic [1:0] pick_id;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    // Counts cycles the current owner has held the grant, including the
    // current one, so an owner gets exactly MAX_HOLD cycles before a forced
    // handoff. A new grant therefore restarts the count at 1.
    logic [7:0] hold_cnt;
    logic       timeout_q;
`endif

    function automatic logic [3:0] id_to_onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

    assign req_vec   = {bus.req_d, bus.req_c, bus.req_b, bus.req_a};
    assign owner_req = req_vec[owner_id];

    // While a grant is owned the owner never competes: either it released
    // (req low) or it is being forced off, and in both cases it must not win
    // the search. In IDLE the last owner is simply the lowest priority.
    always_comb begin
        cand_vec = req_vec;
        if (state == OWN) begin
            cand_vec[owner_id] = 1'b0;
        end
    end

    // Circular search starting one past the current/last owner; offset 4
    // wraps back to the owner itself, which only matters in IDLE.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = owner_id;
        for (int k = 1; k <= 4; k++) begin
            if (!pick_vld && cand_vec[owner_id + 2'(k)]) begin
                pick_vld = 1'b1;
                pick_id  = owner_id + 2'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_vec  <= '0;
            // Last owner = d makes a the first candidate after reset.
            owner_id <= 2'd3;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state    <= OWN;
                        gnt_vec  <= id_to_onehot(pick_id);
                        owner_id <= pick_id;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_cnt <= 8'd1;
`endif
                    end
                end

                OWN: begin
                    if (!owner_req) begin
                        if (pick_vld) begin
                            // Direct handoff, no idle bubble.
                            gnt_vec  <= id_to_onehot(pick_id);
                            owner_id <= pick_id;
`ifdef RR_ARB_TIMEOUT_EN
                            hold_cnt <= 8'd1;
`endif
                        end else begin
                            state   <= IDLE;
                            gnt_vec <= '0;
                        end
                    end
`ifdef RR_ARB_TIMEOUT_EN
                    else if (hold_cnt == HOLD_LIMIT) begin
                        // Hold budget used up: hand off only if someone else
                        // is waiting, otherwise keep the grant and stay
                        // saturated.
                        if (pick_vld) begin
                            gnt_vec   <= id_to_onehot(pick_id);
                            owner_id  <= pick_id;
                            hold_cnt  <= 8'd1;
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end

                default: begin
                    state   <= IDLE;
                    gnt_vec <= '0;
                end
            endcase
        end
    end

    assign bus.gnt_a     = gnt_vec[0];
    assign bus.gnt_b     = gnt_vec[1];
    assign bus.gnt_c     = gnt_vec[2];
    assign bus.gnt_d     = gnt_vec[3];
    assign bus.gnt_valid = |gnt_vec;
    assign bus.gnt_id    = owner_id;

`ifdef RR_ARB_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: directed scenarios plus random requests against a reference model.
// Latency: model advances once per rising edge; DUT sampled on the falling edge.
// Backpressure: requests are levels driven by the bench; no flow control.
module tb_round_robin_arbiter;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int MH = 4;
`else
    localparam int MH = 8;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    round_robin_arbiter_if bus ();

    round_robin_arbiter #(
        .MAX_HOLD(MH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner (-1 = nobody), last owner, cycles held, pulse.
    int   m_owner = -1;
    int   m_last  = 3;
    int   m_hold  = 0;
    logic m_timeout = 1'b0;

    // Independent fairness tracking from the observed grants.
    int         wait_cnt [4];
    logic [3:0] prev_gv = 4'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_search(input logic [3:0] r, input int from, input int n);
        for (int k = 1; k <= n; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic grant_to(input int n);
        m_owner = n;
        m_last  = n;
        m_hold  = 1;
    endtask

    task automatic model_step(input logic [3:0] r, input logic rr);
        int nxt;
        m_timeout = 1'b0;
        if (rr) begin
            m_owner = -1;
            m_last  = 3;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            nxt = rr_search(r, m_last, 4);
            if (nxt >= 0) grant_to(nxt);
        end else if (!r[m_owner]) begin
            nxt = rr_search(r, m_owner, 3);
            if (nxt >= 0) grant_to(nxt);
            else m_owner = -1;
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            if (m_hold >= MH) begin
                nxt = rr_search(r, m_owner, 3);
                if (nxt >= 0) begin
                    grant_to(nxt);
                    m_timeout = 1'b1;
                end
            end else begin
                m_hold++;
            end
`endif
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic rr);
        bus.req_a = r[0];
        bus.req_b = r[1];
        bus.req_c = r[2];
        bus.req_d = r[3];
        rst       = rr;
    endtask

    task automatic compare(input logic [3:0] r, input logic rr);
        logic [3:0] gv;
        logic       new_grant;
        int         worst;
        gv = {bus.gnt_d, bus.gnt_c, bus.gnt_b, bus.gnt_a};
        check("gnt_vec", 32'(gv), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check("gnt_id", 32'(bus.gnt_id), m_last);
        check("gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
        check("timeout", 32'(bus.timeout), 32'(m_timeout));
        check("one_hot", 32'($countones(gv) <= 1), 32'd1);
        check("valid_is_or", 32'(bus.gnt_valid), 32'(|gv));
        check("gnt_without_req", 32'(gv & ~r), 32'd0);
        if (rr) begin
            for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
            prev_gv = 4'b0;
        end else begin
            new_grant = (gv != 4'b0) && (gv != prev_gv);
            worst = 0;
            for (int i = 0; i < 4; i++) begin
                if (!r[i] || gv[i]) wait_cnt[i] = 0;
                else if (new_grant) wait_cnt[i]++;
                if (wait_cnt[i] > worst) worst = wait_cnt[i];
            end
            check("starvation", 32'(worst > 3), 32'd0);
            prev_gv = gv;
        end
    endtask

    // Drive during the low phase, let one edge happen, check on the falling edge.
    task automatic step(input logic [3:0] r, input logic rr);
        drive(r, rr);
        @(posedge clk);
        model_step(r, rr);
        @(negedge clk);
        compare(r, rr);
    endtask

    int exp_ord [5] = '{0, 1, 2, 3, 0};
    int cnt;
    logic [3:0] rq;

    initial begin
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        drive(4'b0000, 1'b1);

        // Reset with all requests high: requests ignored while rst is high.
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        check("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
        check("rst_gnt_id", 32'(bus.gnt_id), 32'd3);

        // All request, each owner drops for one cycle after its grant.
        for (int i = 0; i < 5; i++) begin
            rq = 4'b1111;
            if (m_owner >= 0) rq[m_owner] = 1'b0;
            step(rq, 1'b0);
            check("rr_order", 32'(bus.gnt_id), exp_ord[i]);
        end
        step(4'b0000, 1'b0);

        // Sub-cycle pulse between edges must not be seen.
        bus.req_a = 1'b1;
        #2;
        bus.req_a = 1'b0;
        @(posedge clk);
        model_step(4'b0000, 1'b0);
        @(negedge clk);
        compare(4'b0000, 1'b0);
        check("glitch_ignored", 32'(bus.gnt_valid), 32'd0);

        // Lone req_c for 20 cycles: granted for 19 of them.
        cnt = int'(bus.gnt_c);
        for (int k = 1; k <= 20; k++) begin
            step(4'b0100, 1'b0);
            if (k <= 19) cnt += int'(bus.gnt_c);
        end
        check("hold_c_cycles", cnt, 32'd19);
        step(4'b0000, 1'b0);

        // b owns, releases while a and d wait: d is next after b, no bubble.
        step(4'b0010, 1'b0);
        check("own_b", 32'(bus.gnt_id), 32'd1);
        step(4'b1001, 1'b0);
        check("b_to_d_id", 32'(bus.gnt_id), 32'd3);
        check("b_to_d_gnt", 32'(bus.gnt_d), 32'd1);
        step(4'b0000, 1'b0);

        // Reset while c owns; afterwards a wins over c.
        step(4'b0100, 1'b0);
        check("own_c", 32'(bus.gnt_c), 32'd1);
        step(4'b0101, 1'b1);
        check("rst_drop_gnt", 32'(bus.gnt_valid), 32'd0);
        check("rst_drop_id", 32'(bus.gnt_id), 32'd3);
        step(4'b0101, 1'b0);
        check("after_rst_a", 32'(bus.gnt_id), 32'd0);
        step(4'b0000, 1'b0);

`ifdef RR_ARB_TIMEOUT_EN
        // a and b held high: alternate every MH cycles with a pulse per handoff.
        step(4'b0000, 1'b1);
        cnt = 0;
        for (int k = 1; k <= 4 * MH; k++) begin
            step(4'b0011, 1'b0);
            check("hold_alternate", 32'(bus.gnt_id), 32'(((k - 1) / MH) % 2));
            cnt += int'(bus.timeout);
        end
        check("timeout_pulses", cnt, 32'd3);
        step(4'b0000, 1'b0);
`endif

        // Random requests with rare resets.
        for (int n = 0; n < 10000; n++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 499) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
